// File: rtl/if_stage.sv
// Instruction fetch stage.
//
// Streams sequential instruction addresses to instruction memory over a req/ack handshake.
// Fetched words go into a 2-entry prefetch FIFO, and the FIFO head is presented to decode.
// A branch redirect flushes the FIFO and restarts fetch at the target. If a fetch is still
// outstanding at the redirect, its eventual data is discarded.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   imem_req_o      fetch request, held until acked
//   imem_addr_o     fetch address, stable while imem_req_o=1
//   imem_ack_i      memory completion (only meaningful while imem_req_o=1)
//   imem_data_i     fetched instruction word, valid with imem_ack_i
//   stall_i         decode stall; the head is not consumed while high
//   br_taken_i      one-cycle redirect pulse
//   br_target_i     redirect address, valid with br_taken_i
//   inst_o          instruction to decode (NOP_INST when empty)
//   pc_value_o      PC of inst_o (holds the last head PC when empty)
//   valid_o         inst_o/pc_value_o carry a real fetched instruction
module if_stage #(
   parameter int unsigned        W_PC     = 16,
   parameter int unsigned        W_INST   = 32,
   parameter logic [W_PC-1:0]   RESET_PC = '0,
   parameter logic [W_PC-1:0]   PC_INC   = W_PC'(1),
   parameter logic [W_INST-1:0] NOP_INST = 32'h0800_0000
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_o,
   output logic [W_PC-1:0]   imem_addr_o,
   input  logic              imem_ack_i,
   input  logic [W_INST-1:0] imem_data_i,
   input  logic              stall_i,
   input  logic              br_taken_i,
   input  logic [W_PC-1:0]   br_target_i,
   output logic [W_INST-1:0] inst_o,
   output logic [W_PC-1:0]   pc_value_o,
   output logic              valid_o
);

   typedef enum logic [0:0] {StIdle, StReq} state_e;

   state_e            state_q, state_d;
   logic [1:0]        count_q, count_d;
   logic              discard_q, discard_d;
   logic [W_PC-1:0]   fetch_pc_q, fetch_pc_d;
   logic [W_PC-1:0]   addr_q, addr_d;
   // Entry 0 is always the head; entry 1 is only meaningful when count_q == 2.
   logic [W_PC-1:0]   e0_pc_q, e0_pc_d, e1_pc_q, e1_pc_d;
   logic [W_INST-1:0] e0_inst_q, e0_inst_d, e1_inst_q, e1_inst_d;

   logic fire, push, pop;

   assign imem_req_o  = (state_q == StReq);
   assign imem_addr_o = addr_q;
   assign valid_o     = (count_q != 2'd0);
   assign inst_o      = valid_o ? e0_inst_q : NOP_INST;
   assign pc_value_o  = e0_pc_q;

   always_comb begin
      fire = imem_req_o && imem_ack_i;
      // A redirect kills both the returning word and the head consumption in this cycle.
      push = fire && !discard_q && !br_taken_i;
      pop  = valid_o && !stall_i && !br_taken_i;
   end

   always_comb begin
      count_d    = count_q;
      discard_d  = discard_q;
      fetch_pc_d = fetch_pc_q;
      addr_d     = addr_q;
      state_d    = state_q;
      e0_pc_d    = e0_pc_q;
      e0_inst_d  = e0_inst_q;
      e1_pc_d    = e1_pc_q;
      e1_inst_d  = e1_inst_q;

      // Occupancy
      if (br_taken_i) begin
         count_d = 2'd0;
      end else begin
         case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end

      // Fetch PC: a discarded ack does not advance it, since it already points at the target.
      if (br_taken_i) begin
         fetch_pc_d = br_target_i;
      end else if (fire && !discard_q) begin
         fetch_pc_d = fetch_pc_q + PC_INC;
      end

      // The wrong-path request must still complete; remember to drop its data.
      if (br_taken_i && imem_req_o && !imem_ack_i) begin
         discard_d = 1'b1;
      end else if (fire) begin
         discard_d = 1'b0;
      end

      // The address is frozen while a request is outstanding.
      if (!imem_req_o || fire) begin
         addr_d = fetch_pc_d;
      end

      case (state_q)
         StIdle: if (count_d < 2'd2) state_d = StReq;
         StReq:  if (fire) state_d = (count_d < 2'd2) ? StReq : StIdle;
         default: state_d = StIdle;
      endcase

      // FIFO storage; on a flush the head PC register is left alone so pc_value_o holds.
      if (!br_taken_i) begin
         case ({push, pop})
            2'b10: begin
               if (count_q == 2'd0) begin
                  e0_pc_d   = fetch_pc_q;
                  e0_inst_d = imem_data_i;
               end else begin
                  e1_pc_d   = fetch_pc_q;
                  e1_inst_d = imem_data_i;
               end
            end
            2'b01: begin
               // Popping the last entry keeps the old head PC visible.
               if (count_q == 2'd2) begin
                  e0_pc_d   = e1_pc_q;
                  e0_inst_d = e1_inst_q;
               end
            end
            2'b11: begin
               if (count_q == 2'd1) begin
                  e0_pc_d   = fetch_pc_q;
                  e0_inst_d = imem_data_i;
               end else begin
                  e0_pc_d   = e1_pc_q;
                  e0_inst_d = e1_inst_q;
                  e1_pc_d   = fetch_pc_q;
                  e1_inst_d = imem_data_i;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         count_q    <= 2'd0;
         discard_q  <= 1'b0;
         fetch_pc_q <= RESET_PC;
         addr_q     <= RESET_PC;
         e0_pc_q    <= '0;
         e0_inst_q  <= NOP_INST;
         e1_pc_q    <= '0;
         e1_inst_q  <= NOP_INST;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         discard_q  <= discard_d;
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
         e0_pc_q    <= e0_pc_d;
         e0_inst_q  <= e0_inst_d;
         e1_pc_q    <= e1_pc_d;
         e1_inst_q  <= e1_inst_d;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

   localparam logic [31:0] NOP = 32'h0800_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req_o;
   logic [15:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_data_i;
   logic        stall_i;
   logic        br_taken_i;
   logic [15:0] br_target_i;
   logic [31:0] inst_o;
   logic [15:0] pc_value_o;
   logic        valid_o;

   if_stage dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req_o  (imem_req_o),
      .imem_addr_o (imem_addr_o),
      .imem_ack_i  (imem_ack_i),
      .imem_data_i (imem_data_i),
      .stall_i     (stall_i),
      .br_taken_i  (br_taken_i),
      .br_target_i (br_target_i),
      .inst_o      (inst_o),
      .pc_value_o  (pc_value_o),
      .valid_o     (valid_o)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Memory model: acks once the request has waited 'lat' cycles; data = addr | 0xA000_0000.
   int          mem_lat = 1;
   logic        slow_en = 1'b0;
   logic [15:0] slow_addr = 16'h0005;
   logic [15:0] ack_log[$];

   initial begin
      logic prev_req;
      logic prev_ack;
      int   wcnt;
      int   lat;
      prev_req = 1'b0;
      prev_ack = 1'b0;
      wcnt = 0;
      imem_ack_i = 1'b0;
      imem_data_i = '0;
      forever begin
         @(posedge clk);
         #1;
         if (prev_ack || !prev_req) wcnt = 0;
         else wcnt++;
         lat = (slow_en && imem_addr_o == slow_addr) ? 3 : mem_lat;
         imem_ack_i = imem_req_o && (wcnt >= lat);
         imem_data_i = imem_ack_i ? {16'hA000, imem_addr_o} : 32'h0;
         if (imem_ack_i) ack_log.push_back(imem_addr_o);
         prev_req = imem_req_o;
         prev_ack = imem_ack_i;
      end
   end

   // Scoreboard: expected PCs queued by the stimulus; each consumed head is checked in order.
   logic [15:0] exp_q[$];

   initial begin
      logic [15:0] e;
      forever begin
         @(negedge clk);
         if (rst && valid_o && !stall_i && !br_taken_i && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("deliver", {16'h0, inst_o, pc_value_o}, {16'h0, 16'hA000, e, e});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic hold_reset();
      step();
      rst = 1'b0;
      stall_i = 1'b0;
      br_taken_i = 1'b0;
      slow_en = 1'b0;
      step();
      exp_q.delete();
      ack_log.delete();
   endtask

   task automatic release_reset();
      step();
      rst = 1'b1;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 200) begin
         step();
         n++;
      end
      check(name, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   task automatic wait_req_addr(input string name, input logic [15:0] a);
      int n;
      n = 0;
      while (!(imem_req_o && imem_addr_o == a) && n < 100) begin
         step();
         n++;
      end
      check(name, 64'(imem_req_o && imem_addr_o == a), 64'd1);
   endtask

   function automatic logic [15:0] log_at(input int i);
      if (i < ack_log.size()) return ack_log[i];
      return 16'hxxxx;
   endfunction

   task automatic expect_outputs(input string name, input logic req, input logic [15:0] addr,
                                 input logic vld, input logic [31:0] inst,
                                 input logic [15:0] pc);
      check({name, "_req"}, 64'(imem_req_o), 64'(req));
      check({name, "_addr"}, 64'(imem_addr_o), 64'(addr));
      check({name, "_valid"}, 64'(valid_o), 64'(vld));
      check({name, "_inst"}, 64'(inst_o), 64'(inst));
      check({name, "_pc"}, 64'(pc_value_o), 64'(pc));
   endtask

   initial begin
      int n;
      stall_i = 1'b0;
      br_taken_i = 1'b0;
      br_target_i = '0;

      // T1: reset values, 1-cycle latency streaming
      hold_reset();
      @(negedge clk);
      expect_outputs("reset", 1'b0, 16'h0000, 1'b0, NOP, 16'h0000);
      mem_lat = 1;
      for (int i = 0; i < 6; i++) exp_q.push_back(16'(i));
      release_reset();
      n = 0;
      while (!valid_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t1_first_valid_negedge", 64'(n), 64'd4);
      drain("t1_drain");
      for (int i = 0; i < 4; i++) check("t1_fetch_addr", 64'(log_at(i)), 64'(i));

      // T2: stall holds head pc 4 while the FIFO fills and req drops
      hold_reset();
      mem_lat = 0;
      for (int i = 0; i < 12; i++) exp_q.push_back(16'(i));
      release_reset();
      repeat (6) step();
      stall_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("t2_stall_pc", 64'(pc_value_o), 64'h4);
         check("t2_stall_inst", 64'(inst_o), 64'hA000_0004);
      end
      check("t2_stall_req", 64'(imem_req_o), 64'd0);
      check("t2_stall_valid", 64'(valid_o), 64'd1);
      step();
      stall_i = 1'b0;
      drain("t2_drain");

      // T3: redirect while the fetch of 0x0005 waits 3 cycles
      hold_reset();
      mem_lat = 0;
      slow_en = 1'b1;
      slow_addr = 16'h0005;
      for (int i = 0; i < 4; i++) exp_q.push_back(16'(i));
      for (int i = 0; i < 3; i++) exp_q.push_back(16'h0040 + 16'(i));
      release_reset();
      wait_req_addr("t3_reach_5", 16'h0005);
      br_taken_i = 1'b1;
      br_target_i = 16'h0040;
      step();
      br_taken_i = 1'b0;
      @(negedge clk);
      check("t3_wait_addr", 64'(imem_addr_o), 64'h5);
      check("t3_wait_req", 64'(imem_req_o), 64'd1);
      check("t3_wait_valid", 64'(valid_o), 64'd0);
      step();
      @(negedge clk);
      check("t3_wait2_addr", 64'(imem_addr_o), 64'h5);
      repeat (2) step();
      @(negedge clk);
      check("t3_target_addr", 64'(imem_addr_o), 64'h40);
      check("t3_target_req", 64'(imem_req_o), 64'd1);
      check("t3_dropped_valid", 64'(valid_o), 64'd0);
      drain("t3_drain");
      slow_en = 1'b0;

      // T4: redirect in the same cycle as the ack for 0x0010
      hold_reset();
      mem_lat = 0;
      for (int i = 0; i < 15; i++) exp_q.push_back(16'(i));
      exp_q.push_back(16'h0080);
      exp_q.push_back(16'h0081);
      release_reset();
      wait_req_addr("t4_reach_10", 16'h0010);
      br_taken_i = 1'b1;
      br_target_i = 16'h0080;
      step();
      br_taken_i = 1'b0;
      @(negedge clk);
      check("t4_next_addr", 64'(imem_addr_o), 64'h80);
      check("t4_next_req", 64'(imem_req_o), 64'd1);
      check("t4_flushed_valid", 64'(valid_o), 64'd0);
      drain("t4_drain");

      // T5: redirect to 0xFFFF, address wraps to 0x0000
      hold_reset();
      mem_lat = 0;
      exp_q.push_back(16'hFFFF);
      exp_q.push_back(16'h0000);
      exp_q.push_back(16'h0001);
      release_reset();
      step();
      br_taken_i = 1'b1;
      br_target_i = 16'hFFFF;
      ack_log.delete();
      step();
      br_taken_i = 1'b0;
      drain("t5_drain");
      check("t5_addr0", 64'(log_at(0)), 64'hFFFF);
      check("t5_addr1", 64'(log_at(1)), 64'h0000);
      check("t5_addr2", 64'(log_at(2)), 64'h0001);

      // T6: empty FIFO holds last PC; asynchronous reset while a request waits
      hold_reset();
      mem_lat = 0;
      release_reset();
      wait_req_addr("t6_reach_3", 16'h0003);
      mem_lat = 8;
      repeat (2) step();
      @(negedge clk);
      expect_outputs("t6_before", 1'b1, 16'h0004, 1'b0, NOP, 16'h0003);
      #1;
      rst = 1'b0;
      #1;
      expect_outputs("t6_async_reset", 1'b0, 16'h0000, 1'b0, NOP, 16'h0000);
      mem_lat = 1;
      exp_q.delete();
      for (int i = 0; i < 3; i++) exp_q.push_back(16'(i));
      release_reset();
      step();
      @(negedge clk);
      check("t6_first_req", 64'(imem_req_o), 64'd1);
      check("t6_first_addr", 64'(imem_addr_o), 64'h0);
      drain("t6_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
